// File: rtl/alu_exec_unit.sv
// Execute stage: 1-cycle add/sub/logic/compare, serial shifts (k+1 cycles for shift by k).
// Valid/ready on both sides; the result register holds while OUT_READY=0, and FLUSH aborts in-flight work.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic            ALU_EN,
  input  logic [6:0]      OPCODE,
  input  logic [2:0]      FUNCT3,
  input  logic            FUNCT7_5,
  input  logic [XLEN-1:0] DATA0,
  input  logic [XLEN-1:0] DATA1,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          state_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      cnt_q;
  logic            right_q;
  logic            arith_q;

  logic            accept;
  logic            is_op;
  logic            is_shift;
  logic            sh_right;
  logic            sh_arith;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] acc_shifted;

  assign IN_READY  = ~FLUSH & ((state_q == S_IDLE) | ((state_q == S_DONE) & OUT_READY));
  assign accept    = IN_VALID & IN_READY;
  assign OUT_VALID = (state_q == S_DONE);
  assign BUSY      = (state_q != S_IDLE);
  assign RESULT    = result_q;

  always_comb begin
    alu_res  = '0;
    is_shift = 1'b0;
    sh_right = 1'b0;
    sh_arith = 1'b0;
    is_op    = (OPCODE == OPC_OP) | (OPCODE == OPC_OP_IMM);
    if (ALU_EN) begin
      if (!is_op) begin
        // Loads, stores, LUI and AUIPC only need an address/value sum.
        alu_res = DATA0 + DATA1;
      end else begin
        case (FUNCT3)
          3'b000: alu_res = ((OPCODE == OPC_OP) && FUNCT7_5) ? DATA0 - DATA1 : DATA0 + DATA1;
          3'b001: is_shift = 1'b1;
          3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(DATA0) < $signed(DATA1))};
          3'b011: alu_res = {{(XLEN-1){1'b0}}, (DATA0 < DATA1)};
          3'b100: alu_res = DATA0 ^ DATA1;
          3'b101: begin
            is_shift = 1'b1;
            sh_right = 1'b1;
            sh_arith = FUNCT7_5;
          end
          3'b110: alu_res = DATA0 | DATA1;
          3'b111: alu_res = DATA0 & DATA1;
        endcase
      end
    end
  end

  assign acc_shifted = right_q ? {arith_q & acc_q[XLEN-1], acc_q[XLEN-1:1]}
                               : {acc_q[XLEN-2:0], 1'b0};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      right_q  <= 1'b0;
      arith_q  <= 1'b0;
    end else if (FLUSH) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (is_shift && (DATA1[4:0] != 5'd0)) begin
              acc_q   <= DATA0;
              cnt_q   <= DATA1[4:0];
              right_q <= sh_right;
              arith_q <= sh_arith;
              state_q <= S_SHIFT;
            end else begin
              // A zero-amount shift is just a copy of operand A.
              result_q <= is_shift ? DATA0 : alu_res;
              state_q  <= S_DONE;
            end
          end else if ((state_q == S_DONE) && OUT_READY) begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          acc_q <= acc_shifted;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            result_q <= acc_shifted;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases plus randomized traffic with random back-pressure.
module tb_alu_exec_unit;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] STORE  = 7'b0100011;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        FLUSH = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic        ALU_EN = 1'b0;
  logic [6:0]  OPCODE = '0;
  logic [2:0]  FUNCT3 = '0;
  logic        FUNCT7_5 = 1'b0;
  logic [31:0] DATA0 = '0;
  logic [31:0] DATA1 = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] RESULT;
  logic        BUSY;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  bit          rand_rdy = 1'b0;

  always #5 CLK = ~CLK;

  alu_exec_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_EN(ALU_EN), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7_5(FUNCT7_5),
    .DATA0(DATA0), .DATA1(DATA1), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULT(RESULT), .BUSY(BUSY)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the operation table, using whole-word arithmetic.
  function automatic logic [31:0] model(input bit en, input logic [6:0] opc, input logic [2:0] f3,
                                        input bit f75, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    int sh;
    sa = a;
    sh = int'(b[4:0]);
    if (!en) return 32'd0;
    if (opc != OP && opc != OP_IMM) return a + b;
    case (f3)
      3'd0: return (opc == OP && f75) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f75 ? 32'(sa >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Present one operand set until accepted; expected result is queued at acceptance.
  task automatic issue(input bit en, input logic [6:0] opc, input logic [2:0] f3, input bit f75,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit use_exp, input logic [31:0] exp);
    bit accepted;
    accepted = 1'b0;
    IN_VALID = 1'b1; ALU_EN = en; OPCODE = opc; FUNCT3 = f3; FUNCT7_5 = f75;
    DATA0 = a; DATA1 = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (IN_READY) begin
        exp_q.push_back(use_exp ? exp : model(en, opc, f3, f75, a, b));
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: IN_READY never rose for op f3=%0d", f3);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      cyc++;
      if (OUT_VALID) break;
    end
  endtask

  // Monitor: every output transfer is matched against the oldest expected result.
  logic [31:0] held;
  bit          hold = 1'b0;
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", {31'b0, OUT_VALID}, 32'd1);
          check("hold_result", RESULT, held);
        end
        hold = OUT_VALID && !OUT_READY;
        held = RESULT;
        if (OUT_VALID && OUT_READY) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: got 0x%08h with nothing expected", RESULT);
          end else begin
            check("result", RESULT, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK); #1;
      if (rand_rdy) OUT_READY = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    bit en, f75;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [31:0] a, b;
    int r;
    logic [6:0] other_opc[4];
    other_opc[0] = 7'b0000011; other_opc[1] = STORE;
    other_opc[2] = 7'b0110111; other_opc[3] = 7'b0010111;

    // Reset
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_in_ready", {31'b0, IN_READY}, 32'd1);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    check("rst_result", RESULT, 32'd0);
    check("rst_busy", {31'b0, BUSY}, 32'd0);
    check("rst_in_ready2", {31'b0, IN_READY}, 32'd1);
    @(posedge CLK); #1;

    // SUB vs ADDI
    issue(1, OP, 3'd0, 1, 32'd5, 32'd7, 1, 32'hFFFF_FFFE);
    wait_valid(lat);
    check("sub_latency", lat, 32'd1);
    @(posedge CLK); #1;
    issue(1, OP_IMM, 3'd0, 1, 32'd5, 32'd7, 1, 32'd12);
    wait_valid(lat);
    check("addi_latency", lat, 32'd1);
    @(posedge CLK); #1;

    // SRA by 4
    issue(1, OP, 3'd5, 1, 32'h8000_0010, 32'd4, 1, 32'hF800_0001);
    @(negedge CLK);
    check("sra_in_ready", {31'b0, IN_READY}, 32'd0);
    check("sra_busy", {31'b0, BUSY}, 32'd1);
    check("sra_valid_early", {31'b0, OUT_VALID}, 32'd0);
    wait_valid(lat);
    check("sra_latency", lat + 1, 32'd5);
    @(posedge CLK); #1;

    // Compares and a non-OP opcode
    issue(1, OP_IMM, 3'd2, 0, 32'hFFFF_FFFF, 32'd1, 1, 32'd1);
    issue(1, OP, 3'd3, 0, 32'hFFFF_FFFF, 32'd1, 1, 32'd0);
    issue(1, STORE, 3'd2, 1, 32'hFFFF_FFFF, 32'd1, 1, 32'd0);
    issue(0, OP, 3'd4, 0, 32'h1234_5678, 32'd9, 1, 32'd0);
    wait_valid(lat);
    @(posedge CLK); #1;

    // Back-pressure then back-to-back acceptance
    OUT_READY = 1'b0;
    issue(1, OP, 3'd7, 0, 32'h1234_5678, 32'h0000_FFFF, 1, 32'h0000_5678);
    wait_valid(lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("bp_in_ready", {31'b0, IN_READY}, 32'd0);
      check("bp_result", RESULT, 32'h0000_5678);
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    issue(1, OP_IMM, 3'd4, 0, 32'h0000_00F0, 32'h0000_00FF, 1, 32'h0000_000F);
    @(negedge CLK);
    check("b2b_valid", {31'b0, OUT_VALID}, 32'd1);
    check("b2b_result", RESULT, 32'h0000_000F);
    @(posedge CLK); #1;

    // FLUSH during a shift by 20
    issue(1, OP, 3'd1, 0, 32'd1, 32'd20, 0, 32'd0);
    repeat (5) begin @(posedge CLK); #1; end
    FLUSH = 1'b1;
    @(negedge CLK);
    check("flush_in_ready", {31'b0, IN_READY}, 32'd0);
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    void'(exp_q.pop_back());
    @(negedge CLK);
    check("flush_valid", {31'b0, OUT_VALID}, 32'd0);
    check("flush_busy", {31'b0, BUSY}, 32'd0);
    seen = 1'b0;
    repeat (25) begin @(negedge CLK); if (OUT_VALID) seen = 1'b1; end
    check("flush_no_output", {31'b0, seen}, 32'd0);
    @(posedge CLK); #1;

    // Reset pulsed mid-shift
    issue(1, OP, 3'd5, 0, 32'hFFFF_0000, 32'd16, 0, 32'd0);
    repeat (3) begin @(posedge CLK); #1; end
    RST_N = 1'b0;
    void'(exp_q.pop_back());
    @(negedge CLK);
    check("rst_mid_valid", {31'b0, OUT_VALID}, 32'd0);
    check("rst_mid_busy", {31'b0, BUSY}, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(negedge CLK); if (OUT_VALID) seen = 1'b1; end
    check("rst_mid_no_output", {31'b0, seen}, 32'd0);
    @(posedge CLK); #1;
    issue(1, OP, 3'd0, 0, 32'd1, 32'd1, 1, 32'd2);
    wait_valid(lat);
    check("post_rst_latency", lat, 32'd1);
    @(posedge CLK); #1;

    // Randomized traffic under random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r   = $urandom_range(0, 9);
      en  = (r != 0);
      opc = (r <= 6) ? ((r % 2 == 1) ? OP : OP_IMM) : other_opc[$urandom_range(0, 3)];
      f3  = 3'($urandom);
      f75 = 1'($urandom);
      a   = $urandom;
      b   = $urandom;
      if ($urandom_range(0, 7) == 0) b[4:0] = 5'd0;
      if ($urandom_range(0, 5) == 0) b = a;
      issue(en, opc, f3, f75, a, b, 0, 32'd0);
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end
    rand_rdy = 1'b0;
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge CLK);
    end
    check("drain_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequential execute stage that consumes the operand pair and decode fields produced by the ALU operand-select logic and returns one 32-bit result per accepted operation. Add/sub/logic/compare operations complete in one cycle. Shifts are computed serially, one bit position per cycle, using an iterative shifter. Input and output each use a valid/ready handshake, so the unit can sit between decode and writeback with back-pressure in both directions.

## Interface
Parameters:
- XLEN, 32, datapath width. Only 32 is supported; the shift amount is always 5 bits.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- FLUSH  input  1  synchronous abort of any in-flight operation.
- IN_VALID  input  1  operand set present.
- IN_READY  output  1  unit can accept an operand set this cycle.
- ALU_EN  input  1  operation is an ALU operation; 0 means no ALU op.
- OPCODE  input  7  instruction opcode.
- FUNCT3  input  3  operation select.
- FUNCT7_5  input  1  instruction bit 30 (SUB/SRA select).
- DATA0  input  32  operand A.
- DATA1  input  32  operand B; bits [4:0] are the shift amount for shifts.
- OUT_VALID  output  1  RESULT is valid.
- OUT_READY  input  1  downstream accepts RESULT.
- RESULT  output  32  operation result; held stable while OUT_VALID=1 and OUT_READY=0.
- BUSY  output  1  unit is in the SHIFT or DONE state.

## Operation
- Accept: an operand set is accepted when IN_VALID & IN_READY & ~FLUSH at the clock edge. Operands are captured into internal registers at acceptance.
- Operation decode when OPCODE is 0110011 (OP) or 0010011 (OP-IMM):
  - FUNCT3 000: ADD. SUB instead when OPCODE=0110011 and FUNCT7_5=1.
  - FUNCT3 001: SLL.
  - FUNCT3 010: SLT, signed; RESULT = {31'b0, A<B}.
  - FUNCT3 011: SLTU, unsigned; same result format.
  - FUNCT3 100: XOR.
  - FUNCT3 101: SRL when FUNCT7_5=0, SRA when FUNCT7_5=1.
  - FUNCT3 110: OR.
  - FUNCT3 111: AND.
- Any other opcode with ALU_EN=1 (load, store, LUI, AUIPC): ADD, regardless of FUNCT3 and FUNCT7_5.
- ALU_EN=0: the set is still accepted and produces RESULT=0 with one-cycle latency. This keeps the transaction count aligned with decode.
- ADD and SUB wrap modulo 2^32; no carry or overflow output.
- State machine:
  - IDLE: on accept of a non-shift op, compute the result and go to DONE. On accept of a shift with DATA1[4:0]=0, load DATA0 as the result and go to DONE. On accept of a shift with nonzero amount, load DATA0 into the accumulator and the amount into a 5-bit counter, then go to SHIFT.
  - SHIFT: each cycle, shift the accumulator one position and decrement the counter. SLL fills with 0, SRL fills with 0, SRA fills with the accumulator's bit 31. When the counter reaches 0 after the shift, go to DONE.
  - DONE: OUT_VALID=1. On OUT_READY, go to IDLE, or stay in DONE and load a new non-shift op if one is accepted in the same cycle.
- Handshake rules:
  - IN_READY = ~FLUSH & (state==IDLE | (state==DONE & OUT_READY)).
  - Back-to-back acceptance in DONE: a non-shift op produces its new result in the following cycle. A shift op goes to SHIFT, or to DONE if its amount is 0.
- FLUSH: takes priority over everything. The next state is IDLE, OUT_VALID drops next cycle, and no input is accepted that cycle. RESULT keeps its old value.
- Reset: state=IDLE, RESULT=0, OUT_VALID=0, BUSY=0, counter=0. IN_READY=1 while FLUSH=0. Reset asserted mid-shift discards the operation with no output.

## Timing
- Non-shift op accepted at edge N: OUT_VALID=1 and RESULT valid after edge N, i.e. during cycle N+1.
- Shift by k (k=1..31): OUT_VALID=1 during cycle N+1+k. Shift by 0 behaves as a non-shift op.
- RESULT and OUT_VALID are registered outputs. IN_READY is combinational from state, OUT_READY and FLUSH.
- Sustained throughput with OUT_READY held at 1: one non-shift op per cycle. A shift by k occupies the unit for k+1 cycles.
- With OUT_READY=0, RESULT and OUT_VALID hold indefinitely and IN_READY=0.

## Test plan
- Reset: hold RST_N=0, then release -> OUT_VALID=0, RESULT=0, BUSY=0, IN_READY=1.
- SUB vs ADDI: OPCODE=0110011, FUNCT3=000, FUNCT7_5=1, A=5, B=7 -> RESULT=0xFFFFFFFE after 1 cycle. Same operands with OPCODE=0010011 -> RESULT=12.
- SRA by 4: A=0x80000010, B[4:0]=4 -> RESULT=0xF8000001. OUT_VALID rises 5 cycles after accept. IN_READY=0 during the shift.
- Compare: A=0xFFFFFFFF, B=1 -> SLT gives 1, SLTU gives 0. Store opcode 0100011 with FUNCT3=010 -> RESULT=A+B=0.
- Back-pressure and back-to-back: hold OUT_READY=0 for 3 cycles -> RESULT stable, IN_READY=0. Then raise OUT_READY with IN_VALID=1 (XOR, A=0xF0, B=0xFF) -> the old result is consumed and RESULT=0x0F the next cycle.
- Aborts: FLUSH asserted during a shift by 20 -> IDLE next cycle, OUT_VALID stays 0. RST_N pulsed low mid-shift -> same behaviour, and a subsequent ADD of 1+1 returns 2.
